cu_sequencer: RTL and testbench

- Program sequencer and instruction decoder for the 4-bit computational unit (x0/x1/y0/y1/r/m/i/o_reg/dm datapath).
- Fetches 8-bit instructions from program memory and drives the unit's control inputs: source_sel, reg_en, x_sel, y_sel, i_sel, ir_nibble and sync_reset.
- Supports conditional jumps on r_eq_0 and a hardware repeat (LOOP) of the following instruction.

---
 rtl/cu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_cu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// cu_sequencer: program sequencer and instruction decoder for the 4-bit
// computational unit. Fetches 8-bit instructions from an asynchronous-read
// program memory and drives the unit's control inputs. The decoded controls
// are registered: they are computed from pm_data in FETCH and presented
// during EXEC. reg_en is additionally gated by hold.
// Optional feature macro: CU_SEQ_CALL_EN (CALL/RET with a one-deep ret_pc).
module cu_sequencer #(
  parameter int PC_W         = 8,
  parameter int RST_HOLD_CYC = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  input  logic            hold,
  output logic [PC_W-1:0] pm_addr,
  output logic            sync_reset,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            x_sel,
  output logic            y_sel,
  output logic            i_sel,
  output logic [3:0]      ir_nibble
);

  typedef enum logic [1:0] {RST_HOLD, FETCH, EXEC, JADDR} state_t;

  typedef struct packed {
    logic [3:0] src;
    logic [8:0] en;
    logic       x;
    logic       y;
    logic       i;
    logic [3:0] nib;
  } ctl_t;

  localparam ctl_t       CTL_IDLE  = ctl_t'{4'd10, 9'd0, 1'b0, 1'b0, 1'b0, 4'd0};
  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD_CYC - 1);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [3:0]      r_loop_cnt;
  logic [3:0]      r_hold_cnt;
  logic            r_sync_reset;
  logic            r_taken;
  ctl_t            r_ctl;
  logic            w_is_jump;
  logic            w_is_loop;
  logic            w_taken;
`ifdef CU_SEQ_CALL_EN
  logic [PC_W-1:0] r_ret_pc;
  logic            r_call;
  logic            w_is_ret;
  logic            w_is_call;
`endif

  // Destination field to reg_en bit: o_reg lives at bit 8, not bit 4.
  function automatic logic [8:0] dst_en(input logic [2:0] d);
    logic [8:0] e;
    e = '0;
    case (d)
      3'd0: e[0] = 1'b1;
      3'd1: e[1] = 1'b1;
      3'd2: e[2] = 1'b1;
      3'd3: e[3] = 1'b1;
      3'd4: e[8] = 1'b1;
      3'd5: e[5] = 1'b1;
      3'd6: e[6] = 1'b1;
      default: e[7] = 1'b1;
    endcase
    return e;
  endfunction

  // JUMP, LOOP and RET drive no datapath controls.
  function automatic ctl_t decode(input logic [7:0] ir);
    ctl_t c;
    c = CTL_IDLE;
    if (!ir[7]) begin
      c.src = 4'd8;
      c.nib = ir[3:0];
      c.en  = dst_en(ir[6:4]);
    end else if (ir[7:6] == 2'b10) begin
      c.src = {1'b0, ir[2:0]};
      c.en  = dst_en(ir[5:3]);
      c.i   = (ir == 8'hB6);
    end else if (ir[7:5] == 3'b110) begin
      c.x     = ir[4];
      c.y     = ir[3];
      c.nib   = ir[3:0];
      c.en[4] = 1'b1;
    end
    return c;
  endfunction

  // Classify the latched instruction and resolve the jump condition.
  always_comb begin
    w_is_loop = (r_ir[7:4] == 4'hF);
`ifdef CU_SEQ_CALL_EN
    w_is_ret  = (r_ir == 8'hE4);
    w_is_call = (r_ir == 8'hE3);
    w_is_jump = (r_ir[7:4] == 4'hE) && !w_is_ret;
`else
    w_is_jump = (r_ir[7:4] == 4'hE);
`endif
    case (r_ir[3:0])
      4'd0:    w_taken = 1'b1;
      4'd1:    w_taken = r_eq_0;
      4'd2:    w_taken = !r_eq_0;
`ifdef CU_SEQ_CALL_EN
      4'd3:    w_taken = 1'b1;
`endif
      default: w_taken = 1'b0;
    endcase
  end

  // Sequencer FSM with registered control outputs; hold freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RST_HOLD;
      r_pc         <= '0;
      r_ir         <= 8'hF0;
      r_loop_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_sync_reset <= 1'b1;
      r_taken      <= 1'b0;
      r_ctl        <= CTL_IDLE;
`ifdef CU_SEQ_CALL_EN
      r_ret_pc     <= '0;
      r_call       <= 1'b0;
`endif
    end else if (!hold) begin
      case (r_state)
        RST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= FETCH;
            r_sync_reset <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
        FETCH: begin
          r_ir    <= pm_data;
          r_pc    <= r_pc + PC_W'(1);
          r_ctl   <= decode(pm_data);
          r_state <= EXEC;
        end
        EXEC: begin
          r_ctl <= CTL_IDLE;
`ifdef CU_SEQ_CALL_EN
          if (w_is_ret) begin
            r_pc    <= r_ret_pc;
            r_state <= FETCH;
          end else
`endif
          if (w_is_jump) begin
            r_taken <= w_taken;
`ifdef CU_SEQ_CALL_EN
            r_call  <= w_is_call;
`endif
            r_state <= JADDR;
          end else if (w_is_loop) begin
            r_loop_cnt <= r_ir[3:0];
            r_state    <= FETCH;
          end else if (r_loop_cnt != 4'd0) begin
            // Repeat: keep the same controls for another EXEC cycle.
            r_loop_cnt <= r_loop_cnt - 4'd1;
            r_ctl      <= r_ctl;
          end else begin
            r_state <= FETCH;
          end
        end
        JADDR: begin
          if (r_taken) begin
            r_pc       <= PC_W'(pm_data);
            r_loop_cnt <= '0;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
`ifdef CU_SEQ_CALL_EN
          if (r_call) r_ret_pc <= r_pc + PC_W'(1);
`endif
          r_state <= FETCH;
        end
        default: r_state <= RST_HOLD;
      endcase
    end
  end

  assign pm_addr    = r_pc;
  assign sync_reset = r_sync_reset;
  assign source_sel = r_ctl.src;
  assign reg_en     = hold ? '0 : r_ctl.en;
  assign x_sel      = r_ctl.x;
  assign y_sel      = r_ctl.y;
  assign i_sel      = r_ctl.i;
  assign ir_nibble  = r_ctl.nib;

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: directed programs push expected write
// cycles (cycle index after reset release, pm_addr and controls); a monitor
// pops one entry for every cycle in which reg_en is non-zero.
module tb_cu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic       hold;
  logic [7:0] pm_addr;
  logic       sync_reset;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       x_sel, y_sel, i_sel;
  logic [3:0] ir_nibble;

  logic [7:0] pm [256];
  int         cyc;
  int         n_cmp = 0;
  int         n_fail = 0;

  typedef struct {
    int         c;
    logic [7:0] pc;
    logic [3:0] src;
    logic [8:0] en;
    logic       x, y, i;
    logic [3:0] nib;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  assign pm_data = pm[pm_addr];

  cu_sequencer #(.PC_W(8), .RST_HOLD_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .r_eq_0(r_eq_0),
    .hold(hold), .pm_addr(pm_addr), .sync_reset(sync_reset),
    .source_sel(source_sel), .reg_en(reg_en), .x_sel(x_sel), .y_sel(y_sel),
    .i_sel(i_sel), .ir_nibble(ir_nibble)
  );

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Monitor: every write cycle must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && reg_en != 9'd0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cyc=%0d pm_addr=%h reg_en=%h, required no write",
                 cyc, pm_addr, reg_en);
      end else begin
        mon_e = q.pop_front();
        if (cyc != mon_e.c || pm_addr != mon_e.pc || source_sel != mon_e.src ||
            reg_en != mon_e.en || x_sel != mon_e.x || y_sel != mon_e.y ||
            i_sel != mon_e.i || ir_nibble != mon_e.nib) begin
          n_fail++;
          $display("FAIL write@%0d: got cyc=%0d pc=%h src=%0d en=%h x=%b y=%b i=%b nib=%h; required cyc=%0d pc=%h src=%0d en=%h x=%b y=%b i=%b nib=%h",
                   mon_e.c, cyc, pm_addr, source_sel, reg_en, x_sel, y_sel, i_sel, ir_nibble,
                   mon_e.c, mon_e.pc, mon_e.src, mon_e.en, mon_e.x, mon_e.y, mon_e.i, mon_e.nib);
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] pc, input logic [3:0] src,
                      input logic [8:0] en, input logic x, input logic y,
                      input logic i, input logic [3:0] nib);
    exp_t e;
    e.c = c; e.pc = pc; e.src = src; e.en = en;
    e.x = x; e.y = y; e.i = i; e.nib = nib;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic clear_pm();
    for (int a = 0; a < 256; a++) pm[a] = 8'hF0;
  endtask

  // Reset pulse; releases at posedge+1 so the next posedge is cycle 1.
  task automatic do_reset(input bit detail);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (detail) begin
      check("rst_sync_reset", 32'(sync_reset), 32'd1);
      check("rst_reg_en", 32'(reg_en), 32'd0);
      check("rst_pm_addr", 32'(pm_addr), 32'd0);
      check("rst_source_sel", 32'(source_sel), 32'd10);
      check("rst_ir_nibble", 32'(ir_nibble), 32'd0);
    end
    reset_n = 1'b1;
    if (detail) begin
      @(negedge clk);
      check("hold_sync_c0", 32'(sync_reset), 32'd1);
      @(posedge clk); #1;
      check("hold_sync_c1", 32'(sync_reset), 32'd1);
      check("hold_reg_en_c1", 32'(reg_en), 32'd0);
      @(posedge clk); #1;
      check("fetch_sync_c2", 32'(sync_reset), 32'd0);
      check("fetch_addr_c2", 32'(pm_addr), 32'd0);
      check("fetch_reg_en_c2", 32'(reg_en), 32'd0);
    end
  endtask

  // Wait (bounded) for the scoreboard to drain, then idle to catch extras.
  task automatic wait_done(input string name);
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending writes, required 0", name, q.size());
      q.delete();
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    r_eq_0  = 1'b0;

    // Program A: LOAD x0,5 ; ALU ; JZ 0x10 ; not-taken path at 4.
    clear_pm();
    pm[8'h00] = 8'h05; pm[8'h01] = 8'hC2; pm[8'h02] = 8'hE1; pm[8'h03] = 8'h10;
    pm[8'h04] = 8'h2A; pm[8'h05] = 8'hE0; pm[8'h06] = 8'h05;
    pm[8'h10] = 8'h07; pm[8'h11] = 8'hE0; pm[8'h12] = 8'h11;

    // JZ taken.
    r_eq_0 = 1'b1;
    push(3,  8'h01, 4'd8,  9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
    push(5,  8'h02, 4'd10, 9'h010, 1'b0, 1'b0, 1'b0, 4'h2);
    push(10, 8'h11, 4'd8,  9'h001, 1'b0, 1'b0, 1'b0, 4'h7);
    do_reset(1'b1);
    @(posedge clk); #1;
    check("exec_addr_c3", 32'(pm_addr), 32'd1);
    wait_done("jz_taken");

    // JZ not taken.
    r_eq_0 = 1'b0;
    push(3,  8'h01, 4'd8,  9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
    push(5,  8'h02, 4'd10, 9'h010, 1'b0, 1'b0, 1'b0, 4'h2);
    push(10, 8'h05, 4'd8,  9'h004, 1'b0, 1'b0, 1'b0, 4'hA);
    do_reset(1'b0);
    wait_done("jz_not_taken");

    // LOOP 3 ; MOVE i,i (i <= i+m) -> four back-to-back EXEC cycles.
    clear_pm();
    pm[8'h00] = 8'hF3; pm[8'h01] = 8'hB6; pm[8'h02] = 8'hE0; pm[8'h03] = 8'h02;
    for (int c = 5; c <= 8; c++) push(c, 8'h02, 4'd6, 9'h040, 1'b0, 1'b0, 1'b1, 4'h0);
    do_reset(1'b0);
    wait_done("loop");

    // hold for 3 cycles during the EXEC of MOVE x1,x1.
    clear_pm();
    pm[8'h00] = 8'h05; pm[8'h01] = 8'h89; pm[8'h02] = 8'hE0; pm[8'h03] = 8'h02;
    push(3, 8'h01, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
    push(8, 8'h02, 4'd1, 9'h002, 1'b0, 1'b0, 1'b0, 4'h0);
    do_reset(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_hold_reg_en", 32'(reg_en), 32'h002);
    hold = 1'b1;
    #1;
    check("hold_gate_reg_en", 32'(reg_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_reg_en", 32'(reg_en), 32'd0);
      check("hold_pm_addr", 32'(pm_addr), 32'h02);
    end
    hold = 1'b0;
    wait_done("hold");

    // CALL 0x20 ; at 0x20: LOAD x0,7 ; RET. Without CALL support E3 is a NOP.
    clear_pm();
    pm[8'h00] = 8'hE3; pm[8'h01] = 8'h20; pm[8'h02] = 8'h05;
    pm[8'h03] = 8'hE0; pm[8'h04] = 8'h03;
    pm[8'h20] = 8'h07; pm[8'h21] = 8'hE4;
`ifdef CU_SEQ_CALL_EN
    push(6,  8'h21, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h7);
    push(10, 8'h03, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
`else
    push(6,  8'h03, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
`endif
    do_reset(1'b0);
    wait_done("call");

    // PC wrap: JMP 0xFE ; LOAD at 0xFE ; JMP at 0xFF whose target byte is at 0x00.
    clear_pm();
    pm[8'h00] = 8'hE0; pm[8'h01] = 8'hFE;
    pm[8'hFE] = 8'h05; pm[8'hFF] = 8'hE0;
    pm[8'hE0] = 8'h07; pm[8'hE1] = 8'hE0; pm[8'hE2] = 8'hE1;
    push(6,  8'hFF, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h5);
    push(11, 8'hE1, 4'd8, 9'h001, 1'b0, 1'b0, 1'b0, 4'h7);
    do_reset(1'b0);
    wait_done("pc_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
